// File: rtl/udp_cmd_rx_ctrl_pkg.sv
// Shared frame constants and helpers for the UDP command receiver.
// The host-side test model uses the same values.
package udp_cmd_rx_ctrl_pkg;

  localparam logic [7:0]  HDR0_DEF    = 8'h55;
  localparam logic [7:0]  HDR1_DEF    = 8'hAA;
  localparam logic [7:0]  CMD_START   = 8'h01;
  localparam logic [7:0]  CMD_STOP    = 8'h02;
  localparam logic [15:0] NUM_MAX_DEF = 16'd16384;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    H1       = 3'd1,
    CMD      = 3'd2,
    NH       = 3'd3,
    NL       = 3'd4,
    CS       = 3'd5,
    WAIT_END = 3'd6,
    DROP     = 3'd7
  } rx_state_t;

  // Saturating 8-bit increment used by both frame counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

endpackage

// File: rtl/udp_cmd_rx_ctrl.sv
// Parses 6-byte command frames from a UDP payload stream and issues
// start/stop acquisition requests with a held sample count.
module udp_cmd_rx_ctrl
  import udp_cmd_rx_ctrl_pkg::*;
#(
  parameter logic [15:0] NUM_MAX = NUM_MAX_DEF,
  parameter logic [7:0]  HDR0    = HDR0_DEF,
  parameter logic [7:0]  HDR1    = HDR1_DEF
) (
  input  logic        clk125M,
  input  logic        udp_gmii_rst,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_pkt_done,
  output logic        restart_req,
  output logic        stop_req,
  output logic [15:0] number_val,
  output logic [7:0]  cmd_ok_cnt,
  output logic [7:0]  cmd_err_cnt
);

  rx_state_t   state, state_n;
  logic [7:0]  cmd_b, cmd_n;
  logic [7:0]  num_h, num_h_n;
  logic [7:0]  num_l, num_l_n;
  logic [7:0]  csum, csum_n;
  logic [7:0]  xsum, xsum_n;
  logic [15:0] num_n;
  logic        frame_ok;

  // Post-byte view: the byte of this cycle is consumed before any evaluation.
  always_comb begin
    state_n = state;
    cmd_n   = cmd_b;
    num_h_n = num_h;
    num_l_n = num_l;
    csum_n  = csum;
    xsum_n  = xsum;
    if (rx_data_valid) begin
      case (state)
        IDLE:    state_n = (rx_data == HDR0) ? H1 : DROP;
        H1:      state_n = (rx_data == HDR1) ? CMD : DROP;
        CMD: begin
          cmd_n   = rx_data;
          xsum_n  = rx_data;
          state_n = NH;
        end
        NH: begin
          num_h_n = rx_data;
          xsum_n  = xsum ^ rx_data;
          state_n = NL;
        end
        NL: begin
          num_l_n = rx_data;
          xsum_n  = xsum ^ rx_data;
          state_n = CS;
        end
        CS: begin
          csum_n  = rx_data;
          state_n = WAIT_END;
        end
        default: state_n = state;
      endcase
    end else begin
      state_n = state;
    end
  end

  assign num_n    = {num_h_n, num_l_n};
  assign frame_ok = (state_n == WAIT_END) && (xsum_n == csum_n) &&
                    ((cmd_n == CMD_STOP) ||
                     ((cmd_n == CMD_START) && (num_n >= 16'd1) && (num_n <= NUM_MAX)));

  // Frame FSM, capture registers, counters and registered request pulses.
  always_ff @(posedge clk125M) begin
    if (udp_gmii_rst) begin
      state       <= IDLE;
      cmd_b       <= 8'd0;
      num_h       <= 8'd0;
      num_l       <= 8'd0;
      csum        <= 8'd0;
      xsum        <= 8'd0;
      restart_req <= 1'b0;
      stop_req    <= 1'b0;
      number_val  <= 16'd0;
      cmd_ok_cnt  <= 8'd0;
      cmd_err_cnt <= 8'd0;
    end else begin
      restart_req <= 1'b0;
      stop_req    <= 1'b0;
      state       <= state_n;
      cmd_b       <= cmd_n;
      num_h       <= num_h_n;
      num_l       <= num_l_n;
      csum        <= csum_n;
      xsum        <= xsum_n;
      if (rx_pkt_done) begin
        state <= IDLE;
        if (frame_ok) begin
          cmd_ok_cnt <= sat_inc8(cmd_ok_cnt);
          if (cmd_n == CMD_START) begin
            restart_req <= 1'b1;
            number_val  <= num_n;
          end else begin
            stop_req <= 1'b1;
          end
        end else begin
          cmd_err_cnt <= sat_inc8(cmd_err_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_cmd_rx_ctrl.sv
// Directed, table-driven bench for udp_cmd_rx_ctrl with hand-computed
// expectations plus reset and saturation sequences.
module tb_udp_cmd_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic        done;
  logic        restart_req;
  logic        stop_req;
  logic [15:0] number_val;
  logic [7:0]  cmd_ok_cnt;
  logic [7:0]  cmd_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] b;      // bytes right-aligned, first byte leftmost
    int           n;
    bit           dol;    // done coincides with last byte
    bit           r;
    bit           s;
    logic [15:0]  num;
    logic [7:0]   ok;
    logic [7:0]   err;
  } vec_t;

  vec_t vecs[$];

  udp_cmd_rx_ctrl dut (
    .clk125M      (clk),
    .udp_gmii_rst (rst),
    .rx_data_valid(valid),
    .rx_data      (data),
    .rx_pkt_done  (done),
    .restart_req  (restart_req),
    .stop_req     (stop_req),
    .number_val   (number_val),
    .cmd_ok_cnt   (cmd_ok_cnt),
    .cmd_err_cnt  (cmd_err_cnt)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (restart_req && stop_req) begin
      errors++;
      $display("FAIL req_overlap: restart_req=%0b stop_req=%0b required not both 1", restart_req, stop_req);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [127:0] b, input int n, input bit dol, input bit r, input bit s,
                     input logic [15:0] num, input logic [7:0] ok, input logic [7:0] err);
    vec_t v;
    v.b = b; v.n = n; v.dol = dol; v.r = r; v.s = s; v.num = num; v.ok = ok; v.err = err;
    vecs.push_back(v);
  endtask

  // Drives n bytes then (separately or on the last byte) a done pulse.
  task automatic send(input logic [127:0] b, input int n, input bit dol);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = b[8*(n-1-i) +: 8];
      done  = dol && (i == n - 1);
    end
    if (!dol || n == 0) begin
      @(negedge clk);
      valid = 1'b0;
      data  = 8'h00;
      done  = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
    done  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input bit r, input bit s, input logic [15:0] num,
                               input logic [7:0] ok, input logic [7:0] err);
    chk({tag, "_restart"}, 32'(restart_req), 32'(r));
    chk({tag, "_stop"}, 32'(stop_req), 32'(s));
    chk({tag, "_num"}, 32'(number_val), 32'(num));
    chk({tag, "_ok"}, 32'(cmd_ok_cnt), 32'(ok));
    chk({tag, "_err"}, 32'(cmd_err_cnt), 32'(err));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'({restart_req, stop_req}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 8'h00; done = 1'b0;
    add(128'h55AA0102E0E3, 6, 1'b1, 1'b1, 1'b0, 16'h02E0, 8'd1, 8'd0);
    add(128'h55AA0102E0E4, 6, 1'b1, 1'b0, 1'b0, 16'h02E0, 8'd1, 8'd1);
    add(128'h55AA01400141, 6, 1'b1, 1'b0, 1'b0, 16'h02E0, 8'd1, 8'd2);
    add(128'h55AA01400140, 6, 1'b1, 1'b0, 1'b0, 16'h02E0, 8'd1, 8'd3);
    add(128'h55AA01400041, 6, 1'b1, 1'b1, 1'b0, 16'h4000, 8'd2, 8'd3);
    add(128'h55AA0200000200112233445566778899, 16, 1'b0, 1'b0, 1'b1, 16'h4000, 8'd3, 8'd3);
    add(128'h55AA01000001, 6, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd3, 8'd4);
    add(128'h55AA03000003, 6, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd3, 8'd5);
    add(128'h56AA01000001, 6, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd3, 8'd6);
    add(128'h55AB01000001, 6, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd3, 8'd7);
    add(128'h55AA01000100, 6, 1'b1, 1'b1, 1'b0, 16'h0001, 8'd4, 8'd7);
    add(128'h55AA01FFFF01, 6, 1'b1, 1'b0, 1'b0, 16'h0001, 8'd4, 8'd8);
    add(128'h55AA01,       3, 1'b1, 1'b0, 1'b0, 16'h0001, 8'd4, 8'd9);
    add(128'h55AA01001011, 6, 1'b1, 1'b1, 1'b0, 16'h0010, 8'd5, 8'd9);
    add(128'h0,            0, 1'b0, 1'b0, 1'b0, 16'h0010, 8'd5, 8'd10);
    add(128'h55AA02123424, 6, 1'b1, 1'b0, 1'b1, 16'h0010, 8'd6, 8'd10);
    add(128'h55AA01002021, 6, 1'b0, 1'b1, 1'b0, 16'h0020, 8'd7, 8'd10);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_result("reset", 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b, vecs[i].n, vecs[i].dol);
      expect_result($sformatf("vec%0d", i), vecs[i].r, vecs[i].s, vecs[i].num, vecs[i].ok, vecs[i].err);
    end

    // Reset in the middle of a frame, then its tail and a fresh frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = (i == 0) ? 8'h55 : (i == 1) ? 8'hAA : 8'h01;
    end
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_result("midrst", 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0);
    send(128'h02E0E3, 3, 1'b1);
    expect_result("tail", 1'b0, 1'b0, 16'h0000, 8'd0, 8'd1);
    send(128'h55AA0102E0E3, 6, 1'b1);
    expect_result("postrst", 1'b1, 1'b0, 16'h02E0, 8'd1, 8'd1);

    // Error counter saturation with 300 empty done pulses.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0;
    expect_result("sat", 1'b0, 1'b0, 16'h02E0, 8'd1, 8'hFF);
    send(128'h55AA02000002, 6, 1'b1);
    expect_result("after_sat", 1'b0, 1'b1, 16'h02E0, 8'd2, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
